// File: rtl/vga_pixel_pipeline.sv
// Purpose: turns sync-generator timing into framebuffer reads and emits aligned HSYNC/VSYNC/RGB.
// Latency: RD_LATENCY+1 CE cycles from timing inputs to HSYNC/VSYNC/RGB/FRAME_START (all equal).
// Backpressure: none; CE=0 freezes every register, and the framebuffer must keep up with RD_EN.
//
// Optional feature: define VGA_PIPE_TESTPAT_EN to add the PAT_SEL input and the 8-bar test pattern.
//
// Ports:
//   CLK, RESET_N       clock (rising edge), asynchronous active-low reset
//   CE                 pixel clock enable, shared with the horizontal generator
//   H_SIG/H_BLANK/H_OVF  horizontal generator sync (low in pulse), blanking, last count of line
//   V_SIG/V_BLANK/V_OVF  vertical generator sync, blanking, last line of frame
//   PAT_SEL            (VGA_PIPE_TESTPAT_EN only) 1 = colour bars instead of framebuffer data
//   RD_EN, RD_ADDR     framebuffer read strobe and linear address y*H_DISPLAY+x
//   RD_DATA            {R,G,B} pixel word, sampled on the RD_LATENCY-th CE edge after the
//                      edge that registered RD_EN/RD_ADDR
//   HSYNC, VSYNC       delayed H_SIG/V_SIG
//   R, G, B            pixel colour, forced to 0 in blanking
//   FRAME_START        one CE period, coincident with the first active pixel of a frame on RGB
//   OVERRUN            sticky until the next frame wrap: more active pixels than the frame holds

module vga_pixel_pipeline #(
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int COLOR_W    = 4,
    parameter int ADDR_W     = 19,
    parameter int RD_LATENCY = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CE,
    input  logic                   H_SIG,
    input  logic                   H_BLANK,
    input  logic                   H_OVF,
    input  logic                   V_SIG,
    input  logic                   V_BLANK,
    input  logic                   V_OVF,
`ifdef VGA_PIPE_TESTPAT_EN
    input  logic                   PAT_SEL,
`endif
    output logic                   RD_EN,
    output logic [ADDR_W-1:0]      RD_ADDR,
    input  logic [3*COLOR_W-1:0]   RD_DATA,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic                   FRAME_START,
    output logic                   OVERRUN
);

    localparam int unsigned    NPIX     = H_DISPLAY * V_DISPLAY;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NPIX - 1);
    // Sync and frame-start travel one stage further than 'active', because the
    // colour output register itself forms the last stage of the colour path.
    localparam int             DL       = RD_LATENCY + 1;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic              armed;        // a frame wrap has been seen since reset
    logic [ADDR_W-1:0] addr_cnt;
    logic              max_issued;   // last framebuffer address already read this frame
    logic              active_raw;
    logic              active;
    logic              wrap;
    logic              at_max;
    logic              first_pixel;
    logic              rd_req;

    assign active_raw  = !H_BLANK && !V_BLANK;
    // Until the first wrap after reset we are mid-frame with unknown position,
    // so the remainder of that frame is treated as blanking.
    assign active      = armed && active_raw;
    assign wrap        = H_OVF && V_OVF;
    assign at_max      = (addr_cnt == ADDR_MAX);
    assign first_pixel = active && (addr_cnt == '0);

`ifdef VGA_PIPE_TESTPAT_EN
    assign rd_req = active && !PAT_SEL;
`else
    assign rd_req = active;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_EN      <= 1'b0;
            RD_ADDR    <= '0;
            addr_cnt   <= '0;
            max_issued <= 1'b0;
            armed      <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (CE) begin
            RD_EN   <= rd_req;
            RD_ADDR <= addr_cnt;
            // A wrap takes priority even if it coincides with an active pixel
            // (malformed timing), so the next frame always starts at address 0.
            if (wrap) begin
                addr_cnt   <= '0;
                max_issued <= 1'b0;
                OVERRUN    <= 1'b0;
                armed      <= 1'b1;
            end else if (active) begin
                if (at_max) begin
                    // Saturate: keep re-reading the last address and flag the
                    // excess only once the last address has genuinely been used.
                    max_issued <= 1'b1;
                    if (max_issued) begin
                        OVERRUN <= 1'b1;
                    end
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Delay line: aligns sync, blanking and frame start with read data
    // ------------------------------------------------------------------
    logic [DL-1:0]         hs_dl;
    logic [DL-1:0]         vs_dl;
    logic [DL-1:0]         fp_dl;
    logic [RD_LATENCY-1:0] act_dl;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_dl  <= '1;
            vs_dl  <= '1;
            fp_dl  <= '0;
            act_dl <= '0;
        end else if (CE) begin
            hs_dl[0]  <= H_SIG;
            vs_dl[0]  <= V_SIG;
            fp_dl[0]  <= first_pixel;
            act_dl[0] <= active;
            for (int i = 1; i < DL; i++) begin
                hs_dl[i] <= hs_dl[i-1];
                vs_dl[i] <= vs_dl[i-1];
                fp_dl[i] <= fp_dl[i-1];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                act_dl[i] <= act_dl[i-1];
            end
        end
    end

    assign HSYNC       = hs_dl[DL-1];
    assign VSYNC       = vs_dl[DL-1];
    assign FRAME_START = fp_dl[DL-1];

    // ------------------------------------------------------------------
    // Colour source selection
    // ------------------------------------------------------------------
    logic [3*COLOR_W-1:0] pix_sel;

`ifdef VGA_PIPE_TESTPAT_EN
    localparam int XW = $clog2(H_DISPLAY + 1);

    logic [XW-1:0] x_cnt;
    logic [2:0]    bar;
    logic [2:0]    bar_dl [RD_LATENCY];
    logic [RD_LATENCY-1:0] pat_dl;

    // Bar index across the visible width: 0 at the left edge, 7 at the right.
    assign bar = 3'((32'(x_cnt) * 32'd8) / 32'(H_DISPLAY));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_cnt  <= '0;
            pat_dl <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                bar_dl[i] <= '0;
            end
        end else if (CE) begin
            if (H_OVF) begin
                x_cnt <= '0;
            end else if (active_raw) begin
                x_cnt <= x_cnt + 1'b1;
            end
            // PAT_SEL is sampled with the pixel so a change applies from the
            // next active pixel onward and stays aligned with blanking.
            pat_dl[0] <= PAT_SEL;
            bar_dl[0] <= bar;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pat_dl[i] <= pat_dl[i-1];
                bar_dl[i] <= bar_dl[i-1];
            end
        end
    end

    always_comb begin
        pix_sel = RD_DATA;
        if (pat_dl[RD_LATENCY-1]) begin
            pix_sel = {{COLOR_W{bar_dl[RD_LATENCY-1][2]}},
                       {COLOR_W{bar_dl[RD_LATENCY-1][1]}},
                       {COLOR_W{bar_dl[RD_LATENCY-1][0]}}};
        end
    end
`else
    assign pix_sel = RD_DATA;
`endif

    // ------------------------------------------------------------------
    // Output colour register (final pipeline stage)
    // ------------------------------------------------------------------
    logic [3*COLOR_W-1:0] rgb_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb_q <= '0;
        end else if (CE) begin
            rgb_q <= act_dl[RD_LATENCY-1] ? pix_sel : '0;
        end
    end

    assign R = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign G = rgb_q[2*COLOR_W-1:COLOR_W];
    assign B = rgb_q[COLOR_W-1:0];

endmodule
